// File: rtl/adder_accum_seq_pkg.sv
// Shared types and helpers for the adder_accum_seq operand stager.
// Opcode and state encodings live here.
// Saturation limits are provided as width-based helper functions.
package adder_accum_pkg;

  localparam int DATA_W = 32;
  localparam int OPC_W  = 2;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_ADD  = 2'd1,
    OP_ADDC = 2'd2,
    OP_ACC  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Largest positive two's-complement value of a w-bit word (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word (w <= 64).
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Signed overflow: both operands share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_accum_seq_if.sv
// Request/result handshake bundle for adder_accum_seq.
// master = producer/consumer side, slave = the stager itself.
interface adder_accum_seq_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/adder_accum_seq.sv
// adder_accum_seq: stages operands into an external combinational adder,
// captures its sum/carry one cycle later and returns them over a
// valid/ready handshake. Keeps an accumulator and carry flag so ADDC/ACC
// chains run through one adder instance.
// Optional macro ADDER_ACCUM_SAT_EN: signed saturation for ADD/ACC plus o_ovf.
module adder_accum_seq
  import adder_accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_accum_seq_if.slave  bus,
  output logic [WIDTH-1:0]  o_add_a,
  output logic [WIDTH-1:0]  o_add_b,
  output logic              o_add_cin,
  input  logic [WIDTH-1:0]  i_add_s,
  input  logic              i_add_cout
`ifdef ADDER_ACCUM_SAT_EN
  ,
  output logic              o_ovf
`endif
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_load;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic             w_cin;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_cin;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_valid;

`ifdef ADDER_ACCUM_SAT_EN
  localparam logic [63:0] SAT_MAX_W = sat_max(WIDTH);
  localparam logic [63:0] SAT_MIN_W = sat_min(WIDTH);
  op_e  r_op;
  logic w_ovf;
  logic r_ovf;
`endif

  // Next-state decode and request acceptance; in_ready in HOLD follows out_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = EXEC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXEC: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_load      = 1'b1;
            w_state_nxt = EXEC;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand selection for the adder from the incoming opcode.
  always_comb begin
    w_opa = bus.in_a;
    w_opb = bus.in_b;
    w_cin = 1'b0;
    case (op_e'(bus.in_op))
      OP_LOAD: begin
        w_opa = bus.in_a;
        w_opb = {WIDTH{1'b0}};
        w_cin = 1'b0;
      end
      OP_ADD: begin
        w_opa = bus.in_a;
        w_opb = bus.in_b;
        w_cin = 1'b0;
      end
      OP_ADDC: begin
        w_opa = bus.in_a;
        w_opb = bus.in_b;
        w_cin = r_carry;
      end
      OP_ACC: begin
        w_opa = r_acc;
        w_opb = bus.in_b;
        w_cin = 1'b0;
      end
      default: begin
        w_opa = bus.in_a;
        w_opb = bus.in_b;
        w_cin = 1'b0;
      end
    endcase
  end

  // Result shaping: raw adder sum, clamped on signed overflow when saturation is built in.
  always_comb begin
    w_res = i_add_s;
`ifdef ADDER_ACCUM_SAT_EN
    w_ovf = 1'b0;
    if (((r_op == OP_ADD) || (r_op == OP_ACC)) &&
        signed_ovf(r_add_a[WIDTH-1], r_add_b[WIDTH-1], i_add_s[WIDTH-1])) begin
      w_ovf = 1'b1;
      w_res = r_add_a[WIDTH-1] ? SAT_MIN_W[WIDTH-1:0] : SAT_MAX_W[WIDTH-1:0];
    end else begin
      w_ovf = 1'b0;
    end
`endif
  end

  // State, staged operands, accumulator/carry and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_add_a     <= {WIDTH{1'b0}};
      r_add_b     <= {WIDTH{1'b0}};
      r_add_cin   <= 1'b0;
      r_acc       <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_out_sum   <= {WIDTH{1'b0}};
      r_out_cout  <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ADDER_ACCUM_SAT_EN
      r_op        <= OP_LOAD;
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_add_a   <= w_opa;
        r_add_b   <= w_opb;
        r_add_cin <= w_cin;
`ifdef ADDER_ACCUM_SAT_EN
        r_op      <= op_e'(bus.in_op);
`endif
      end
      if (r_state == EXEC) begin
        r_out_sum   <= w_res;
        r_out_cout  <= i_add_cout;
        r_acc       <= w_res;
        r_carry     <= i_add_cout;
        r_out_valid <= 1'b1;
`ifdef ADDER_ACCUM_SAT_EN
        r_ovf       <= w_ovf;
`endif
      end else if ((r_state == HOLD) && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign o_add_a       = r_add_a;
  assign o_add_b       = r_add_b;
  assign o_add_cin     = r_add_cin;
`ifdef ADDER_ACCUM_SAT_EN
  assign o_ovf         = r_ovf;
`endif

endmodule
